// File: rtl/aes_encipher_ctrl.sv
// Round/word sequencer for the word-serial AES encipher datapath with a shared 32-bit S-box.
// Optional S-box grant stalls are enabled by defining AES_ENCIPHER_CTRL_SBOX_STALL_EN.
module aes_encipher_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       next,
    input  logic [1:0] keylen,
    input  logic       sbox_gnt,
    output logic       sbox_req,
    output logic [3:0] round,
    output logic [1:0] round_type,
    output logic [1:0] sword_ctr,
    output logic [3:0] word_we,
    output logic       block_we,
    output logic       ready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_SBOX   = 2'd2,
        ST_UPDATE = 2'd3
    } state_e;

    localparam logic [1:0] RT_INIT  = 2'd0;
    localparam logic [1:0] RT_MAIN  = 2'd1;
    localparam logic [1:0] RT_FINAL = 2'd2;
    localparam logic [1:0] RT_NONE  = 2'd3;

    state_e     state_q, state_d;
    logic [1:0] keylen_q, keylen_d;
    logic [3:0] round_q, round_d;
    logic [1:0] sword_ctr_q, sword_ctr_d;
    logic [3:0] last_round;
    logic       is_final;
    logic       gnt;

`ifdef AES_ENCIPHER_CTRL_SBOX_STALL_EN
    assign gnt = sbox_gnt;
`else
    // Grant is ignored in this build; the port stays for interface compatibility.
    logic unused_sbox_gnt;
    assign unused_sbox_gnt = sbox_gnt;
    assign gnt = 1'b1;
`endif

    always_comb begin
        case (keylen_q)
            2'd1:    last_round = 4'd12;
            2'd2:    last_round = 4'd14;
            default: last_round = 4'd10;
        endcase
    end

    assign is_final = (round_q == last_round);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            keylen_q    <= 2'd0;
            round_q     <= 4'd0;
            sword_ctr_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            keylen_q    <= keylen_d;
            round_q     <= round_d;
            sword_ctr_q <= sword_ctr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        keylen_d    = keylen_q;
        round_d     = round_q;
        sword_ctr_d = sword_ctr_q;
        ready       = 1'b0;
        round_type  = RT_NONE;
        sbox_req    = 1'b0;
        word_we     = 4'b0000;
        block_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (next) begin
                    keylen_d = keylen;
                    round_d  = 4'd0;
                    state_d  = ST_INIT;
                end
            end
            ST_INIT: begin
                round_type  = RT_INIT;
                block_we    = 1'b1;
                round_d     = 4'd1;
                sword_ctr_d = 2'd0;
                state_d     = ST_SBOX;
            end
            ST_SBOX: begin
                sbox_req   = 1'b1;
                round_type = is_final ? RT_FINAL : RT_MAIN;
                if (gnt) begin
                    // Counter wraps 3 -> 0 naturally as the last word is written.
                    word_we     = 4'b0001 << sword_ctr_q;
                    sword_ctr_d = sword_ctr_q + 2'd1;
                    if (sword_ctr_q == 2'd3) begin
                        state_d = ST_UPDATE;
                    end
                end
            end
            ST_UPDATE: begin
                block_we   = 1'b1;
                round_type = is_final ? RT_FINAL : RT_MAIN;
                if (is_final) begin
                    state_d = ST_IDLE;
                end else begin
                    round_d = round_q + 4'd1;
                    state_d = ST_SBOX;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign round     = round_q;
    assign sword_ctr = sword_ctr_q;

endmodule

// File: tb/tb_aes_encipher_ctrl.sv
// Self-checking bench for aes_encipher_ctrl: per-cycle comparison against a trace
// generated from the round/word schedule (INIT, then per round 4 S-box words and an update).
module tb_aes_encipher_ctrl;

    logic       clk;
    logic       reset_n;
    logic       next;
    logic [1:0] keylen;
    logic       sbox_gnt;
    logic       sbox_req;
    logic [3:0] round;
    logic [1:0] round_type;
    logic [1:0] sword_ctr;
    logic [3:0] word_we;
    logic       block_we;
    logic       ready;

`ifdef AES_ENCIPHER_CTRL_SBOX_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    aes_encipher_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .next       (next),
        .keylen     (keylen),
        .sbox_gnt   (sbox_gnt),
        .sbox_req   (sbox_req),
        .round      (round),
        .round_type (round_type),
        .sword_ctr  (sword_ctr),
        .word_we    (word_we),
        .block_we   (block_we),
        .ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rnd;
        logic [1:0] rtype;
        logic [3:0] wwe;
        logic       bwe;
        logic       req;
        logic [1:0] sctr;
    } exp_t;

    exp_t exp_q[$];
    bit   gnt_pat[0:299];
    int   checks = 0;
    int   errors = 0;

    function automatic int n_rounds(input logic [1:0] kl);
        if (kl == 2'd1) return 12;
        if (kl == 2'd2) return 14;
        return 10;
    endfunction

    task automatic fill_gnt(input int mode);
        for (int i = 0; i < 300; i++) begin
            if (mode == 0) gnt_pat[i] = 1'b1;
            else           gnt_pat[i] = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Expected busy-cycle trace for one operation under the current grant pattern.
    task automatic build_model(input logic [1:0] kl);
        exp_t e;
        int   k;
        int   n;
        exp_q.delete();
        n = n_rounds(kl);
        k = 0;
        e.rnd = 4'd0; e.rtype = 2'd0; e.wwe = 4'd0; e.bwe = 1'b1; e.req = 1'b0; e.sctr = 2'd0;
        exp_q.push_back(e);
        k++;
        for (int r = 1; r <= n; r++) begin
            for (int w = 0; w < 4; w++) begin
                while (STALL_EN && !gnt_pat[k] && k < 250) begin
                    e.rnd = 4'(r); e.rtype = (r == n) ? 2'd2 : 2'd1; e.wwe = 4'd0;
                    e.bwe = 1'b0; e.req = 1'b1; e.sctr = 2'(w);
                    exp_q.push_back(e);
                    k++;
                end
                e.rnd = 4'(r); e.rtype = (r == n) ? 2'd2 : 2'd1; e.wwe = 4'(1 << w);
                e.bwe = 1'b0; e.req = 1'b1; e.sctr = 2'(w);
                exp_q.push_back(e);
                k++;
            end
            e.rnd = 4'(r); e.rtype = (r == n) ? 2'd2 : 2'd1; e.wwe = 4'd0;
            e.bwe = 1'b1; e.req = 1'b0; e.sctr = 2'd0;
            exp_q.push_back(e);
            k++;
        end
    endtask

    // Called in a cycle where ready is high (after #1); starts the op in that same cycle.
    task automatic run_op(input logic [1:0] kl, input int next_at, input string name,
                          output int busy);
        exp_t e;
        int   n;
        n = n_rounds(kl);
        build_model(kl);
        next   = 1'b1;
        keylen = kl;
        busy   = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            next     = (k == next_at);
            keylen   = (k == next_at) ? 2'd2 : 2'($urandom);
            sbox_gnt = gnt_pat[k];
            #1;
            if (ready) break;
            busy++;
            checks++;
            if (k < exp_q.size()) begin
                e = exp_q[k];
                if (round !== e.rnd || round_type !== e.rtype || word_we !== e.wwe ||
                    block_we !== e.bwe || sbox_req !== e.req || sword_ctr !== e.sctr) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got rnd=%0d type=%0d wwe=%b bwe=%b req=%b sctr=%0d, want rnd=%0d type=%0d wwe=%b bwe=%b req=%b sctr=%0d",
                             name, k, round, round_type, word_we, block_we, sbox_req, sword_ctr,
                             e.rnd, e.rtype, e.wwe, e.bwe, e.req, e.sctr);
                end
            end else begin
                errors++;
                $display("FAIL %s cycle %0d: still busy, expected ready after %0d cycles",
                         name, k, exp_q.size());
            end
        end
        checks++;
        if (busy != exp_q.size()) begin
            errors++;
            $display("FAIL %s busy: got %0d cycles, want %0d", name, busy, exp_q.size());
        end
        checks++;
        if (ready !== 1'b1 || round_type !== 2'd3 || round !== 4'(n) || word_we !== 4'd0 ||
            block_we !== 1'b0 || sbox_req !== 1'b0) begin
            errors++;
            $display("FAIL %s done: got ready=%b type=%0d rnd=%0d wwe=%b bwe=%b req=%b, want 1/3/%0d/0000/0/0",
                     name, ready, round_type, round, word_we, block_we, sbox_req, n);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (ready !== 1'b1 || round !== 4'd0 || sword_ctr !== 2'd0 || round_type !== 2'd3 ||
            sbox_req !== 1'b0 || word_we !== 4'd0 || block_we !== 1'b0) begin
            errors++;
            $display("FAIL %s: got ready=%b rnd=%0d sctr=%0d type=%0d req=%b wwe=%b bwe=%b, want 1/0/0/3/0/0000/0",
                     name, ready, round, sword_ctr, round_type, sbox_req, word_we, block_we);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b1;
        next     = 1'b0;
        keylen   = 2'd0;
        sbox_gnt = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        @(negedge clk);
        reset_n = 1'b1;
        #1 check_reset_outputs("reset_release");
    endtask

    task automatic test_keylens();
        int busy;
        fill_gnt(0);
        for (int kl = 0; kl < 4; kl++) begin
            run_op(2'(kl), -1, "keylen", busy);
            checks++;
            if (busy != 1 + 5 * n_rounds(2'(kl))) begin
                errors++;
                $display("FAIL keylen%0d latency: got %0d, want %0d", kl, busy, 1 + 5 * n_rounds(2'(kl)));
            end
        end
    endtask

    task automatic test_stall();
        int busy;
        fill_gnt(0);
        gnt_pat[3] = 1'b0;
        gnt_pat[4] = 1'b0;
        gnt_pat[5] = 1'b0;
        run_op(2'd0, -1, "stall", busy);
        checks++;
        if (busy != (STALL_EN ? 54 : 51)) begin
            errors++;
            $display("FAIL stall latency: got %0d, want %0d", busy, STALL_EN ? 54 : 51);
        end
    endtask

    task automatic test_random_stall();
        int busy;
        for (int i = 0; i < 4; i++) begin
            fill_gnt(1);
            run_op(2'($urandom), -1, "rand_stall", busy);
        end
    endtask

    task automatic test_next_ignored();
        int busy;
        fill_gnt(0);
        run_op(2'd0, 20, "next_ignored", busy);
        checks++;
        if (busy != 51) begin
            errors++;
            $display("FAIL next_ignored latency: got %0d, want 51", busy);
        end
    endtask

    task automatic test_reset_mid();
        int busy;
        fill_gnt(0);
        next     = 1'b1;
        keylen   = 2'd0;
        sbox_gnt = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            next = 1'b0;
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid busy: got ready=%b, want 0", ready);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1 check_reset_outputs("reset_mid");
        @(negedge clk);
        reset_n = 1'b1;
        #1 check_reset_outputs("reset_mid_release");
        run_op(2'd0, -1, "after_reset", busy);
        checks++;
        if (busy != 51) begin
            errors++;
            $display("FAIL after_reset latency: got %0d, want 51", busy);
        end
    endtask

    task automatic test_back_to_back();
        int busy;
        fill_gnt(0);
        run_op(2'd1, -1, "b2b_first", busy);
        run_op(2'd0, -1, "b2b_second", busy);
        checks++;
        if (busy != 51) begin
            errors++;
            $display("FAIL b2b latency: got %0d, want 51", busy);
        end
    endtask

    initial begin
        test_reset();
        test_keylens();
        test_stall();
        test_random_stall();
        test_next_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
